// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
package regfile_arb_pkg;

    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned GID_W      = 3;   // requester index width, up to 8 requesters
    localparam int unsigned CNT_W      = 6;   // clear counter, holds 1..NUM_REGS

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clear_state_t;

    // Round-robin successor of idx among n requesters.
    function automatic logic [GID_W-1:0] rr_next(input logic [GID_W-1:0] idx,
                                                 input int unsigned      n);
        int unsigned nxt;
        nxt = 32'(idx) + 32'd1;
        return (nxt >= n) ? '0 : GID_W'(nxt);
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin grant: first requester at or after ptr (mod N) wins.
module rr_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0]     req,
    input  logic [GID_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [GID_W-1:0] idx
);

    // Pick the requester with the smallest circular distance from ptr.
    always_comb begin
        int unsigned best;
        int unsigned best_i;
        int unsigned d;
        best   = N;
        best_i = 0;
        d      = 0;
        grant  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i]) begin
                d = (i >= 32'(ptr)) ? (i - 32'(ptr)) : (i + N - 32'(ptr));
                if (d < best) begin
                    best   = d;
                    best_i = i;
                end
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            grant[i] = (best < N) && (best_i == i);
        end
        idx = GID_W'(best_i);
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the register-file write port among NUM_REQ requesters.
// Optional clear sequencer (zeroes registers 1..31) enabled by REGFILE_ARB_CLEAR_EN.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W
) (
    input  logic                      clock,
    input  logic                      ctrl_reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      ctrl_writeEnable,
    output logic [ADDR_W-1:0]         ctrl_writeReg,
    output logic [DATA_W-1:0]         data_writeReg,
    output logic [GID_W-1:0]          grant_id
`ifdef REGFILE_ARB_CLEAR_EN
    ,
    input  logic                      clear_start,
    output logic                      clear_done
`endif
);

    logic [GID_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] arb_grant;
    logic [GID_W-1:0]   arb_idx;
    logic               hs;
    logic               busy;
    logic               clr_wr;
    logic [ADDR_W-1:0]  clr_addr;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // Ready is held low in reset and while the clear sequencer owns the port.
    assign req_ready = (ctrl_reset_n && !busy) ? arb_grant : '0;
    assign hs        = |req_ready;

    // Select the winning requester's address and data.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef REGFILE_ARB_CLEAR_EN
    clear_state_t     state;
    logic [CNT_W-1:0] cnt;

    // Clear FSM: walk cnt 1..31, then one idle cycle before DONE so that
    // clear_done follows the last write on the port.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clear_start) begin
                        state <= ST_CLEAR;
                        cnt   <= CNT_W'(1);
                    end
                end
                ST_CLEAR: begin
                    if (cnt == CNT_W'(NUM_REGS)) begin
                        state      <= ST_DONE;
                        clear_done <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (state != ST_IDLE);
    assign clr_wr   = (state == ST_CLEAR) && (cnt != CNT_W'(NUM_REGS));
    assign clr_addr = ADDR_W'(cnt);
`else
    assign busy     = 1'b0;
    assign clr_wr   = 1'b0;
    assign clr_addr = '0;
`endif

    // Pointer moves past the requester that completed a handshake.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            rr_ptr <= '0;
        end else if (hs) begin
            rr_ptr <= rr_next(arb_idx, NUM_REQ);
        end
    end

    // Write stage: register the clear write or the winning request; r0 is never enabled.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= '0;
            data_writeReg    <= '0;
            grant_id         <= '0;
        end else if (clr_wr) begin
            ctrl_writeEnable <= 1'b1;
            ctrl_writeReg    <= clr_addr;
            data_writeReg    <= '0;
            grant_id         <= '0;
        end else if (hs) begin
            ctrl_writeEnable <= (sel_addr != '0);
            ctrl_writeReg    <= sel_addr;
            data_writeReg    <= sel_data;
            grant_id         <= arb_idx;
        end else begin
            ctrl_writeEnable <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter (NUM_REQ=3, DATA_W=32, ADDR_W=5).
// Clear-sequencer checks are built when REGFILE_ARB_CLEAR_EN is defined.
`timescale 1ns/1ps
module tb_regfile_write_arbiter;

    localparam int unsigned NR    = 3;
    localparam int unsigned NROWS = 17;

    logic            clock = 1'b0;
    logic            ctrl_reset_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*5-1:0] req_addr;
    logic [NR*32-1:0] req_data;
    logic            ctrl_writeEnable;
    logic [4:0]      ctrl_writeReg;
    logic [31:0]     data_writeReg;
    logic [2:0]      grant_id;
`ifdef REGFILE_ARB_CLEAR_EN
    logic            clear_start;
    logic            clear_done;
`endif

    typedef struct {
        logic [2:0]  valid;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic [2:0]  exp_ready;
    } vec_t;

    typedef struct {
        logic        hs;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [2:0]  gid;
    } wr_t;

    vec_t        tbl [NROWS];
    wr_t         sb [$];
    logic [31:0] rf [32];
    int          errors = 0;
    int          checks = 0;

    always #5 clock = ~clock;

    regfile_write_arbiter #(.NUM_REQ(NR), .DATA_W(32), .ADDR_W(5)) dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_addr         (req_addr),
        .req_data         (req_data),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .grant_id         (grant_id)
`ifdef REGFILE_ARB_CLEAR_EN
        ,
        .clear_start      (clear_start),
        .clear_done       (clear_done)
`endif
    );

    // Register file fed by the write port.
    always @(posedge clock) begin
        if (ctrl_writeEnable) rf[ctrl_writeReg] <= data_writeReg;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [2:0] v, input logic [4:0] a0, a1, a2,
                         input logic [31:0] d0, d1, d2);
        req_valid = v;
        req_addr  = {a2, a1, a0};
        req_data  = {d2, d1, d0};
    endtask

    task automatic check_port_zero(input string tag);
        check({tag, " we"},   32'(ctrl_writeEnable), 32'd0);
        check({tag, " reg"},  32'(ctrl_writeReg),    32'd0);
        check({tag, " data"}, data_writeReg,         32'd0);
        check({tag, " gid"},  32'(grant_id),         32'd0);
        check({tag, " ready"}, 32'(req_ready),       32'd0);
    endtask

    function automatic vec_t mk(input logic [2:0] v, input logic [4:0] a0, a1, a2,
                                input logic [31:0] d0, d1, d2, input logic [2:0] er);
        vec_t t;
        t.valid = v;  t.a0 = a0; t.a1 = a1; t.a2 = a2;
        t.d0 = d0;    t.d1 = d1; t.d2 = d2; t.exp_ready = er;
        return t;
    endfunction

    initial begin
        vec_t v;
        wr_t  e;
        logic seen_done;

        foreach (rf[i]) rf[i] = '0;

        // Round robin over three busy requesters, then register-0 and pointer corner cases.
        tbl[0]  = mk(3'b111, 5, 6, 7, 32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 3'b001);
        tbl[1]  = mk(3'b111, 5, 6, 7, 32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 3'b010);
        tbl[2]  = mk(3'b111, 5, 6, 7, 32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 3'b100);
        tbl[3]  = mk(3'b111, 5, 6, 7, 32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 3'b001);
        tbl[4]  = mk(3'b111, 5, 6, 7, 32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 3'b010);
        tbl[5]  = mk(3'b111, 5, 6, 7, 32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 3'b100);
        tbl[6]  = mk(3'b010, 5, 0, 7, 32'h1111_0000, 32'hDEAD_BEEF, 32'h3333_0000, 3'b010);
        tbl[7]  = mk(3'b111, 5, 6, 7, 32'h1111_0001, 32'h2222_0001, 32'h3333_0001, 3'b100);
        tbl[8]  = mk(3'b011, 5, 6, 7, 32'h1111_0001, 32'h2222_0001, 32'h3333_0001, 3'b001);
        tbl[9]  = mk(3'b110, 5, 6, 8, 32'h1111_0001, 32'h2222_0001, 32'h3333_0002, 3'b010);
        tbl[10] = mk(3'b101, 10, 6, 8, 32'h1111_0002, 32'h2222_0001, 32'h3333_0002, 3'b100);
        tbl[11] = mk(3'b001, 10, 6, 8, 32'h1111_0002, 32'h2222_0001, 32'h3333_0002, 3'b001);
        tbl[12] = mk(3'b000, 10, 6, 8, 32'h1111_0002, 32'h2222_0001, 32'h3333_0002, 3'b000);
        tbl[13] = mk(3'b100, 10, 6, 9, 32'h1111_0002, 32'h2222_0001, 32'h1234_5678, 3'b100);
        tbl[14] = mk(3'b011, 31, 1, 9, 32'hFFFF_FFFF, 32'h0000_0001, 32'h1234_5678, 3'b001);
        tbl[15] = mk(3'b010, 31, 1, 9, 32'hFFFF_FFFF, 32'h0000_0001, 32'h1234_5678, 3'b010);
        tbl[16] = mk(3'b001, 3, 1, 9, 32'h0BAD_F00D, 32'h0000_0001, 32'h1234_5678, 3'b001);

        // Reset with every requester valid.
        ctrl_reset_n = 1'b0;
`ifdef REGFILE_ARB_CLEAR_EN
        clear_start = 1'b0;
`endif
        drive(3'b111, 5, 6, 7, 32'h1111_0000, 32'h2222_0000, 32'h3333_0000);
        repeat (3) @(posedge clock);
        #1;
        check_port_zero("reset");
`ifdef REGFILE_ARB_CLEAR_EN
        check("reset clear_done", 32'(clear_done), 32'd0);
`endif
        ctrl_reset_n = 1'b1;

        // Table: drive, check ready, push expected write, compare after the edge.
        for (int r = 0; r < int'(NROWS); r++) begin
            v = tbl[r];
            drive(v.valid, v.a0, v.a1, v.a2, v.d0, v.d1, v.d2);
            #1;
            check($sformatf("row%0d ready", r), 32'(req_ready), 32'(v.exp_ready));
            e = '{1'b0, 1'b0, 5'd0, 32'd0, 3'd0};
            case (v.exp_ready)
                3'b001:  e = '{1'b1, (v.a0 != 5'd0), v.a0, v.d0, 3'd0};
                3'b010:  e = '{1'b1, (v.a1 != 5'd0), v.a1, v.d1, 3'd1};
                3'b100:  e = '{1'b1, (v.a2 != 5'd0), v.a2, v.d2, 3'd2};
                default: e.hs = 1'b0;
            endcase
            sb.push_back(e);
            step();
            e = sb.pop_front();
            check($sformatf("row%0d we", r), 32'(ctrl_writeEnable), 32'(e.we));
            if (e.hs) check($sformatf("row%0d gid", r), 32'(grant_id), 32'(e.gid));
            if (e.we) begin
                check($sformatf("row%0d reg", r), 32'(ctrl_writeReg), 32'(e.addr));
                check($sformatf("row%0d data", r), data_writeReg, e.data);
            end
            if (r == 14) check("rf[9] readback", rf[9], 32'h1234_5678);
        end
        check("rf[0] untouched", rf[0], 32'd0);
        check("rf[31] readback", rf[31], 32'hFFFF_FFFF);

        // Asynchronous reset mid-stream clears outputs and the pointer.
        drive(3'b111, 5, 6, 7, 32'h1111_0000, 32'h2222_0000, 32'h3333_0000);
        ctrl_reset_n = 1'b0;
        #1;
        check_port_zero("midreset");
        step();
        step();
        ctrl_reset_n = 1'b1;
        #1;
        check("post-reset ready", 32'(req_ready), 32'b001);
        step();
        check("post-reset we", 32'(ctrl_writeEnable), 32'd1);
        check("post-reset reg", 32'(ctrl_writeReg), 32'd5);
        check("post-reset data", data_writeReg, 32'h1111_0000);
        req_valid = '0;
        step();

`ifdef REGFILE_ARB_CLEAR_EN
        // Clear sequence with requester 0 raised once CLEAR has started.
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        drive(3'b001, 4, 6, 7, 32'h0000_0044, 32'h2222_0000, 32'h3333_0000);
        #1;
        check("clr start ready", 32'(req_ready), 32'd0);
        for (int k = 1; k <= 31; k++) begin
            step();
            check($sformatf("clr%0d we", k),   32'(ctrl_writeEnable), 32'd1);
            check($sformatf("clr%0d reg", k),  32'(ctrl_writeReg),    32'(k));
            check($sformatf("clr%0d data", k), data_writeReg,         32'd0);
            check($sformatf("clr%0d gid", k),  32'(grant_id),         32'd0);
            check($sformatf("clr%0d ready", k), 32'(req_ready),       32'd0);
            check($sformatf("clr%0d done", k), 32'(clear_done),       32'd0);
        end
        step();
        check("clr done pulse", 32'(clear_done), 32'd1);
        check("clr done we", 32'(ctrl_writeEnable), 32'd0);
        check("clr done ready", 32'(req_ready), 32'd0);
        step();
        check("clr done drop", 32'(clear_done), 32'd0);
        check("clr resume ready", 32'(req_ready), 32'b001);
        step();
        check("clr resume we", 32'(ctrl_writeEnable), 32'd1);
        check("clr resume reg", 32'(ctrl_writeReg), 32'd4);
        check("clr resume data", data_writeReg, 32'h0000_0044);
        req_valid = '0;
        step();
        check("rf[5] cleared", rf[5], 32'd0);
        check("rf[31] cleared", rf[31], 32'd0);
        check("rf[4] rewritten", rf[4], 32'h0000_0044);

        // Reset part-way through a clear aborts it without clear_done.
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        repeat (12) step();
        check("abort reg", 32'(ctrl_writeReg), 32'd12);
        ctrl_reset_n = 1'b0;
        #1;
        check_port_zero("abort");
        check("abort clear_done", 32'(clear_done), 32'd0);
        step();
        ctrl_reset_n = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 36; k++) begin
            step();
            seen_done = seen_done | clear_done;
        end
        check("abort no clear_done", 32'(seen_done), 32'd0);
        drive(3'b111, 5, 6, 7, 32'h1111_0000, 32'h2222_0000, 32'h3333_0000);
        #1;
        check("abort resume ready", 32'(req_ready), 32'b001);
        step();
        req_valid = '0;
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 32 x 32-bit register file among several writeback requesters (ALU, load unit, multiply/divide unit) using round-robin arbitration. Each requester uses a valid/ready handshake. The winning request is registered onto the regfile write port one cycle later. An optional clear sequencer walks registers 1..31 and writes zero to each.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- DATA_W, 32, write data width
- ADDR_W, 5, register address width

Ports:
- clock  in  1  single clock, rising edge
- ctrl_reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester write request
- req_ready  out  NUM_REQ  per-requester grant; handshake when valid && ready
- req_addr  in  NUM_REQ*ADDR_W  destination register, requester i at bits [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  write data, same packing
- ctrl_writeEnable  out  1  to regfile write enable
- ctrl_writeReg  out  ADDR_W  to regfile write address
- data_writeReg  out  DATA_W  to regfile write data
- grant_id  out  3  index of the requester driving the current write
- clear_start  in  1  start clear sequence (REGFILE_ARB_CLEAR_EN only)
- clear_done  out  1  one-cycle pulse at end of clear (REGFILE_ARB_CLEAR_EN only)

## Operation
- Requester protocol:
  - Once raised, req_valid, req_addr and req_data are held stable until the handshake.
  - Requesters do not depend on ready to raise valid.
- Arbitration (combinational on the current inputs):
  - Scan from rr_ptr upward, modulo NUM_REQ. The first valid requester gets req_ready.
  - At most one req_ready bit is high per cycle.
  - A request presented while no other requester is pending is granted in the same cycle.
- Pointer update: on a handshake by requester i, rr_ptr <= (i+1) mod NUM_REQ. With no handshake, rr_ptr holds.
- Write stage (registered): on a handshake, the next cycle drives
  - ctrl_writeEnable=1
  - ctrl_writeReg=addr, data_writeReg=data
  - grant_id=i
  With no handshake, the next cycle drives ctrl_writeEnable=0; addr and data hold their last values.
- Register 0: a request to address 0 is handshaken normally and rr_ptr advances, but ctrl_writeEnable stays 0 for it.
- Clear FSM (under the macro), states IDLE, CLEAR, DONE:
  - IDLE -> CLEAR on clear_start; clear counter cnt=1.
  - In CLEAR: req_ready=0; each cycle writes data=0 to register cnt with grant_id=0; cnt increments.
  - CLEAR -> DONE after the write to register 31. DONE -> IDLE unconditionally; clear_done=1 only in DONE.
  - clear_start is ignored outside IDLE.
  - A pending request is held by its requester through CLEAR and DONE. Arbitration resumes in IDLE from the preserved rr_ptr.

## Timing
- Reset values (asynchronous, immediate):
  - ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0
  - grant_id=0, rr_ptr=0, FSM=IDLE, clear_done=0
- Ready:
  - req_ready is combinational from req_valid, rr_ptr and FSM state.
  - req_ready is forced to 0 while ctrl_reset_n is low.
- Latency:
  - Handshake at edge N: write port valid from edge N until edge N+1.
  - The regfile commits at edge N+1; readable data appears after edge N+1.
- Throughput: one write per cycle sustained. Each of k continuously valid requesters is granted exactly once every k cycles.
- Clear: 31 write cycles plus 1 DONE cycle. clear_start at edge N gives clear_done high during cycle N+32.
- Reset mid-clear aborts the sequence, with no clear_done. Registers already cleared stay cleared.

## Configuration
- REGFILE_ARB_CLEAR_EN defined: clear FSM, counter, clear_start and clear_done ports are present.
- Not defined:
  - The ports, FSM and counter are absent.
  - The block is permanently in IDLE behaviour.

## Structure
- Package regfile_arb_pkg holds:
  - NUM_REGS=32, default ADDR_W and DATA_W
  - the clear FSM state enum (IDLE, CLEAR, DONE)
- Sub-module rr_arbiter holds the round-robin grant logic:
  - inputs: request vector, pointer
  - outputs: one-hot grant, encoded index
  - It is reused by any later read-port sharing.
- The top-level holds the rr_ptr register, write-stage registers and clear FSM.

## Test plan
- Reset with all req_valid=1 -> all outputs 0, req_ready=0. After release, req_ready=3'b001 and the next cycle drives ctrl_writeReg/data_writeReg from requester 0.
- Requesters 0,1,2 continuously valid with addrs 5,6,7 -> grant_id sequence 0,1,2,0,1,2, ctrl_writeEnable=1 every cycle.
- Requester 1 alone writes reg 0 with data 32'hDEADBEEF -> req_ready[1]=1, following cycle ctrl_writeEnable=0, and next grant starts scanning at requester 2.
- Requester 2 writes reg 9 with data 32'h12345678 at edge N -> regfile read of reg 9 returns 32'h12345678 after edge N+1.
- REGFILE_ARB_CLEAR_EN, clear_start pulse with requester 0 valid -> 31 writes of 0 to regs 1..31 in order, req_ready=0 throughout, clear_done at cycle N+32, requester 0 granted the cycle after.
- Assert ctrl_reset_n low at cnt=12 during clear -> outputs 0 immediately, no clear_done; after release, normal arbitration with rr_ptr=0.
